// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial ALU sequencer driving one external 1-bit ALU slice.
// It latches the operands and the control word, then walks the slice LSB first,
// one bit per clock. The carry is chained through carry_q, and the slice result
// bits are collected in a shift register.
// SLT takes two passes. The first pass is a subtraction that produces the
// overflow-corrected sign. The second pass uses the slice Less input to
// build the 0/1 result word.
// Optional feature: define ALU_OVERFLOW_EN to build the registered Overflow flag.
// Without it, Overflow is tied to 0.
module alu_serial_seq #(
    parameter int WIDTH = 24
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       ALUCtrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             SliceA,
    output logic             SliceB,
    output logic             SliceCIN,
    output logic             SliceBInvert,
    output logic             SliceLess,
    output logic [1:0]       SliceOp,
    input  logic             SliceResult,
    input  logic             SliceCarryOut
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        SETPASS = 2'b10,
        DONE    = 2'b11
    } state_t;

    state_t state;
    state_t state_nxt;

    // Latched request.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       ctrl_q;

    // Serial datapath state.
    logic [IDX_W-1:0] idx;
    logic             carry_q;
    logic             set_q;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nxt;

    logic is_slt;
    logic last_bit;
    logic msb_ovf;
    logic accept;

    assign is_slt   = (ctrl_q[1:0] == OP_SLT);
    assign last_bit = (idx == LAST_IDX);
    // Signed overflow of the first pass: carry into the MSB differs from carry out.
    assign msb_ovf  = carry_q ^ SliceCarryOut;
    assign accept   = (state == IDLE) && Start;

    // The shift register with the bit currently on the slice merged in.
    always_comb begin
        shreg_nxt      = shreg;
        shreg_nxt[idx] = SliceResult;
    end

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic plus status and slice drive. Every Slice* output idles at 0.
    always_comb begin
        state_nxt    = state;
        Busy         = 1'b1;
        Done         = 1'b0;
        SliceA       = 1'b0;
        SliceB       = 1'b0;
        SliceCIN     = 1'b0;
        SliceBInvert = 1'b0;
        SliceLess    = 1'b0;
        SliceOp      = OP_AND;
        case (state)
            IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                SliceA   = a_q[idx];
                SliceB   = b_q[idx];
                SliceCIN = carry_q;
                if (is_slt) begin
                    // The first SLT pass is a plain A-B.
                    SliceOp      = OP_ADD;
                    SliceBInvert = 1'b1;
                end else begin
                    SliceOp      = ctrl_q[1:0];
                    SliceBInvert = ctrl_q[2];
                end
                if (last_bit) begin
                    state_nxt = is_slt ? SETPASS : DONE;
                end
            end
            SETPASS: begin
                SliceOp   = OP_SLT;
                SliceLess = (idx == '0) & set_q;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                Done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand latch, serial bit walk, and the Result/Zero update on entry to DONE.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            idx     <= '0;
            carry_q <= 1'b0;
            set_q   <= 1'b0;
            shreg   <= '0;
            Result  <= '0;
            Zero    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q     <= A;
                        b_q     <= B;
                        ctrl_q  <= ALUCtrl;
                        idx     <= '0;
                        // SLT subtracts on its first pass, so it needs carry-in 1.
                        carry_q <= ALUCtrl[2] | (ALUCtrl[1:0] == OP_SLT);
                    end
                end
                RUN: begin
                    carry_q <= SliceCarryOut;
                    shreg   <= shreg_nxt;
                    idx     <= idx + IDX_W'(1);
                    if (last_bit) begin
                        if (is_slt) begin
                            // Take the sign of A-B, corrected by overflow.
                            set_q <= SliceResult ^ msb_ovf;
                            idx   <= '0;
                        end else begin
                            Result <= shreg_nxt;
                            Zero   <= (shreg_nxt == '0);
                        end
                    end
                end
                SETPASS: begin
                    shreg <= shreg_nxt;
                    idx   <= idx + IDX_W'(1);
                    if (last_bit) begin
                        Result <= shreg_nxt;
                        Zero   <= (shreg_nxt == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ALU_OVERFLOW_EN
    // The overflow flag is reported only for ADD/SUB. It is held until the next completion.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Overflow <= 1'b0;
        end else if (state == RUN && last_bit && !is_slt) begin
            Overflow <= (ctrl_q[1:0] == OP_ADD) & msb_ovf;
        end else if (state == SETPASS && last_bit) begin
            Overflow <= 1'b0;
        end
    end
`else
    assign Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// tb_alu_serial_seq: drives alu_serial_seq through a behavioural 1-bit ALU slice.
// It compares each operation against a word-level reference model that uses signed arithmetic.
// ALU_OVERFLOW_EN selects which Overflow values are expected.
module tb_alu_serial_seq;

    localparam int W = 24;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         Start;
    logic [2:0]   ALUCtrl;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Result;
    logic         Zero;
    logic         Overflow;
    logic         SliceA;
    logic         SliceB;
    logic         SliceCIN;
    logic         SliceBInvert;
    logic         SliceLess;
    logic [1:0]   SliceOp;
    logic         SliceResult;
    logic         SliceCarryOut;

    int n_chk  = 0;
    int n_fail = 0;

    alu_serial_seq #(.WIDTH(W)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Start        (Start),
        .ALUCtrl      (ALUCtrl),
        .A            (A),
        .B            (B),
        .Busy         (Busy),
        .Done         (Done),
        .Result       (Result),
        .Zero         (Zero),
        .Overflow     (Overflow),
        .SliceA       (SliceA),
        .SliceB       (SliceB),
        .SliceCIN     (SliceCIN),
        .SliceBInvert (SliceBInvert),
        .SliceLess    (SliceLess),
        .SliceOp      (SliceOp),
        .SliceResult  (SliceResult),
        .SliceCarryOut(SliceCarryOut)
    );

    always #5 Clock = ~Clock;

    // External ALU1 slice: classic 1-bit ALU with B invert and a Less input.
    logic bb;
    always_comb begin
        bb = SliceB ^ SliceBInvert;
        case (SliceOp)
            2'b00:   SliceResult = SliceA & bb;
            2'b01:   SliceResult = SliceA | bb;
            2'b10:   SliceResult = SliceA ^ bb ^ SliceCIN;
            default: SliceResult = SliceLess;
        endcase
        SliceCarryOut = (SliceA & bb) | (SliceA & SliceCIN) | (bb & SliceCIN);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word-level reference: signed integer arithmetic on whole operands.
    task automatic ref_model(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                             output logic [W-1:0] r, output logic ov);
        longint sa;
        longint sb;
        longint t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ov = 1'b0;
        case (c[1:0])
            2'b00: r = a & (c[2] ? ~b : b);
            2'b01: r = a | (c[2] ? ~b : b);
            2'b10: begin
                t  = c[2] ? (sa - sb) : (sa + sb);
                r  = t[W-1:0];
                ov = (t > longint'((1 << (W-1)) - 1)) || (t < -longint'(1 << (W-1)));
            end
            default: r = (sa < sb) ? W'(1) : W'(0);
        endcase
    endtask

    logic [W-1:0] last_res;

    task automatic run_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int pulse_at, input bit start_in_done);
        logic [W-1:0] er;
        logic         eo;
        logic [1:0]   eop;
        logic         einv;
        logic         slt;
        int           cyc;
        int           lat;
        int           slice_bad;
        int           extra_done;
        bit           got;
        ref_model(c, a, b, er, eo);
`ifndef ALU_OVERFLOW_EN
        eo = 1'b0;
`endif
        slt  = (c[1:0] == 2'b11);
        lat  = slt ? 2 * W : W;
        eop  = slt ? 2'b10 : c[1:0];
        einv = slt ? 1'b1 : c[2];
        ALUCtrl = c;
        A       = a;
        B       = b;
        Start   = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        check("busy_after_start", Busy, 1);
        check("cin_bit0", SliceCIN, c[2] | slt);
        cyc = 0;
        got = 0;
        slice_bad = 0;
        while (!got && cyc <= 2 * W + 4) begin
            if (cyc < W) begin
                if (SliceA !== a[cyc] || SliceB !== b[cyc] || SliceOp !== eop ||
                    SliceBInvert !== einv || SliceLess !== 1'b0 || Busy !== 1'b1 || Done !== 1'b0)
                    slice_bad++;
            end else if (slt && cyc < 2 * W) begin
                if (SliceOp !== 2'b11 || SliceBInvert !== 1'b0 || SliceCIN !== 1'b0 ||
                    SliceLess !== ((cyc == W) ? er[0] : 1'b0) || Busy !== 1'b1 || Done !== 1'b0)
                    slice_bad++;
            end
            if (cyc == pulse_at) begin
                Start   = 1'b1;
                A       = ~a;
                B       = a ^ b;
                ALUCtrl = 3'b001;
            end else if (cyc == pulse_at + 1) begin
                Start = 1'b0;
            end
            if (Done === 1'b1) got = 1;
            else begin
                @(posedge Clock); #1;
                cyc++;
            end
        end
        check("slice_drive", slice_bad, 0);
        check("done_seen", got, 1);
        check("latency", cyc, lat);
        check("result", Result, er);
        check("zero", Zero, (er == '0));
        check("overflow", Overflow, eo);
        check("busy_in_done", Busy, 1);
        check("slice_idle_done", {SliceA, SliceB, SliceCIN, SliceBInvert, SliceLess, SliceOp}, 0);
        last_res = er;
        if (start_in_done) begin
            Start = 1'b1;
            @(posedge Clock); #1;
            check("start_in_done_ignored", Busy, 0);
        end else begin
            @(posedge Clock); #1;
            check("done_one_cycle", Done, 0);
            check("idle_after_done", Busy, 0);
            check("result_held", Result, er);
        end
        if (pulse_at >= 0) begin
            extra_done = 0;
            repeat (2 * W + 4) begin
                if (Done !== 1'b0 || Busy !== 1'b0) extra_done++;
                @(posedge Clock); #1;
            end
            check("busy_start_dropped", extra_done, 0);
            check("result_after_drop", Result, er);
        end
    endtask

    logic [W-1:0] edge_vals [4];

    initial begin
        int cnt;
        logic [2:0] rc;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        edge_vals[0] = '0;
        edge_vals[1] = 24'h7FFFFF;
        edge_vals[2] = 24'h800000;
        edge_vals[3] = 24'hFFFFFF;

        // Reset together with Start: reset wins and every output is 0.
        Reset = 1'b1; Start = 1'b1; ALUCtrl = 3'b010; A = 24'h123456; B = 24'h654321;
        repeat (3) @(posedge Clock);
        #1;
        Start = 1'b0;
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_result", Result, 0);
        check("rst_zero", Zero, 0);
        check("rst_overflow", Overflow, 0);
        check("rst_slice", {SliceA, SliceB, SliceCIN, SliceBInvert, SliceLess, SliceOp}, 0);
        Reset = 1'b0;
        @(posedge Clock); #1;
        check("idle_after_rst", Busy, 0);

        // ADD.
        run_op(3'b010, 24'h000005, 24'h000003, -1, 0);
        check("add_const", Result, 24'h000008);
        // SUB with signed overflow.
        run_op(3'b110, 24'h7FFFFF, 24'hFFFFFF, -1, 0);
        check("sub_const", Result, 24'h800000);
`ifdef ALU_OVERFLOW_EN
        check("sub_ovf_const", Overflow, 1);
`else
        check("sub_ovf_const", Overflow, 0);
`endif
        // SLT cases.
        run_op(3'b111, 24'hFFFFFE, 24'h000001, -1, 0);
        check("slt_neg_const", Result, 24'h000001);
        run_op(3'b111, 24'h000001, 24'hFFFFFE, -1, 0);
        check("slt_swap_const", Result, 24'h000000);
        check("slt_swap_zero", Zero, 1);
        run_op(3'b111, 24'h800000, 24'h000001, -1, 0);
        check("slt_ovf_const", Result, 24'h000001);
        // AND with B inverted, then OR with B inverted.
        run_op(3'b100, 24'hF0F0F0, 24'hFF0000, -1, 0);
        check("andinv_const", Result, 24'h00F0F0);
        run_op(3'b101, 24'h000000, 24'hFFFF00, -1, 0);
        check("orinv_const", Result, 24'h0000FF);
        // Start pulsed while busy.
        run_op(3'b010, 24'h000005, 24'h000003, 5, 0);
        check("busy_pulse_const", Result, 24'h000008);

        // Reset in RUN cycle 10.
        ALUCtrl = 3'b010; A = 24'h0ABCDE; B = 24'h012345; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (9) @(posedge Clock);
        #1;
        check("pre_reset_busy", Busy, 1);
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        check("midrst_busy", Busy, 0);
        check("midrst_done", Done, 0);
        check("midrst_result", Result, 0);
        check("midrst_overflow", Overflow, 0);
        check("midrst_slice", {SliceA, SliceB, SliceCIN, SliceBInvert, SliceLess, SliceOp}, 0);
        cnt = 0;
        repeat (2 * W) begin
            if (Done !== 1'b0 || Busy !== 1'b0) cnt++;
            @(posedge Clock); #1;
        end
        check("midrst_no_done", cnt, 0);
        run_op(3'b010, 24'h0ABCDE, 24'h012345, -1, 0);
        check("post_rst_add_const", Result, 24'h0BE023);

        // Start held during the DONE cycle, then accepted from IDLE.
        run_op(3'b011, 24'h000010, 24'h000020, -1, 1);
        run_op(3'b000, 24'hABCDEF, 24'h0F0F0F, -1, 0);

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            rc = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : W'($urandom);
            run_op(rc, ra, rb, -1, (i < 39) && ($urandom_range(0, 4) == 0));
        end
        Start = 1'b0;
        repeat (3) @(posedge Clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
